// File: rtl/clk_gen_multi.sv
// clk_gen_multi: NUM_CH independent divided clocks from clk, each with
// programmable high/low/phase; shadowed config, clean start/stop.
//
// Ports:
//   clk, rst_n           reference clock, async active-low reset
//   cfg_we, cfg_ch       config write strobe and target channel
//   cfg_high/low/phase   high, low and start-phase times (clk cycles)
//   start, stop          per-channel level requests
//   clk_out              generated clocks (registered)
//   running              channel in PHASE, HIGH or LOW
//   rise_pulse           strobe in the cycle clk_out goes 0->1
//   cfg_err              strobe the cycle after a rejected write
module clk_gen_multi #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_high,
  input  logic [CNT_W-1:0]  cfg_low,
  input  logic [CNT_W-1:0]  cfg_phase,
  input  logic [NUM_CH-1:0] start,
  input  logic [NUM_CH-1:0] stop,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] running,
  output logic [NUM_CH-1:0] rise_pulse,
  output logic              cfg_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PHASE,
    S_HIGH,
    S_LOW
  } state_t;

  localparam logic [CH_W:0] LP_NCH =
    (CH_W+1)'(NUM_CH);
  localparam logic [CNT_W-1:0] LP_ONE =
    CNT_W'(1);

  logic w_ch_ok;
  logic w_cfg_ok;
  logic w_cfg_bad;
  logic r_cfg_err;

  assign w_ch_ok = ({1'b0, cfg_ch} < LP_NCH);

  assign w_cfg_ok = cfg_we
                 && w_ch_ok
                 && (cfg_high != '0)
                 && (cfg_low != '0);

  assign w_cfg_bad = cfg_we && !w_cfg_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= w_cfg_bad;
    end
  end

  assign cfg_err = r_cfg_err;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_sh_high;
    logic [CNT_W-1:0] r_sh_low;
    logic [CNT_W-1:0] r_sh_phase;
    logic [CNT_W-1:0] r_act_high;
    logic [CNT_W-1:0] r_act_low;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_stop_pend;
    logic             w_stop_pend_nxt;
    logic             w_load_act;
    logic             w_cnt_done;
    logic             w_wr;
    logic             w_go;
    logic             r_clk;
    logic             r_rise;

    assign w_wr = w_cfg_ok
               && (cfg_ch == CH_W'(g));

    assign w_go = start[g] && !stop[g];

    assign w_cnt_done = (r_cnt == '0);

    // Shadow registers: written by accepted
    // config, never read by a period in flight.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sh_high  <= LP_ONE;
        r_sh_low   <= LP_ONE;
        r_sh_phase <= '0;
      end else if (w_wr) begin
        r_sh_high  <= cfg_high;
        r_sh_low   <= cfg_low;
        r_sh_phase <= cfg_phase;
      end
    end

    // Phase is consumed straight from the
    // shadow at launch, so only high/low
    // need an active copy.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_act_high <= LP_ONE;
        r_act_low  <= LP_ONE;
      end else if (w_load_act) begin
        r_act_high <= r_sh_high;
        r_act_low  <= r_sh_low;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state     <= S_IDLE;
        r_cnt       <= '0;
        r_stop_pend <= 1'b0;
      end else begin
        r_state     <= w_state_nxt;
        r_cnt       <= w_cnt_nxt;
        r_stop_pend <= w_stop_pend_nxt;
      end
    end

    // Counters hold value-1 on entry and
    // the state ends when they reach 0.
    always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_stop_pend_nxt = r_stop_pend;
      w_load_act      = 1'b0;
      unique case (r_state)
        S_IDLE: begin
          w_stop_pend_nxt = 1'b0;
          if (w_go) begin
            w_load_act = 1'b1;
            if (r_sh_phase != '0) begin
              w_state_nxt = S_PHASE;
              w_cnt_nxt   = r_sh_phase - LP_ONE;
            end else begin
              w_state_nxt = S_HIGH;
              w_cnt_nxt   = r_sh_high - LP_ONE;
            end
          end
        end
        S_PHASE: begin
          if (stop[g]) begin
            w_state_nxt = S_IDLE;
          end else if (w_cnt_done) begin
            w_state_nxt = S_HIGH;
            w_cnt_nxt   = r_act_high - LP_ONE;
          end else begin
            w_cnt_nxt = r_cnt - LP_ONE;
          end
        end
        S_HIGH: begin
          w_stop_pend_nxt = r_stop_pend
                         || stop[g];
          if (w_cnt_done) begin
            w_state_nxt = S_LOW;
            w_cnt_nxt   = r_act_low - LP_ONE;
          end else begin
            w_cnt_nxt = r_cnt - LP_ONE;
          end
        end
        S_LOW: begin
          if (w_cnt_done) begin
            if (r_stop_pend || stop[g]) begin
              w_state_nxt     = S_IDLE;
              w_stop_pend_nxt = 1'b0;
            end else begin
              // New period: pick up any
              // config written meanwhile.
              w_state_nxt = S_HIGH;
              w_load_act  = 1'b1;
              w_cnt_nxt   = r_sh_high - LP_ONE;
            end
          end else begin
            w_stop_pend_nxt = r_stop_pend
                           || stop[g];
            w_cnt_nxt = r_cnt - LP_ONE;
          end
        end
        default: begin
          w_state_nxt     = S_IDLE;
          w_stop_pend_nxt = 1'b0;
        end
      endcase
    end

    // clk_out trails the state by one edge,
    // so a start at edge k rises at k+1+phase.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_clk  <= 1'b0;
        r_rise <= 1'b0;
      end else begin
        r_clk  <= (r_state == S_HIGH);
        r_rise <= (r_state == S_HIGH)
               && !r_clk;
      end
    end

    assign clk_out[g]    = r_clk;
    assign rise_pulse[g] = r_rise;
    assign running[g]    = (r_state != S_IDLE);

  end

endmodule

// File: tb/tb_clk_gen_multi.sv
// tb_clk_gen_multi: directed checks of clk_gen_multi
// (NUM_CH=6, CNT_W=8) with immediate assertions.
module tb_clk_gen_multi;

  localparam int NCH = 6;
  localparam int CW  = 8;
  localparam int CHW = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           cfg_we;
  logic [CHW-1:0] cfg_ch;
  logic [CW-1:0]  cfg_high;
  logic [CW-1:0]  cfg_low;
  logic [CW-1:0]  cfg_phase;
  logic [NCH-1:0] start;
  logic [NCH-1:0] stop;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] running;
  logic [NCH-1:0] rise_pulse;
  logic           cfg_err;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  clk_gen_multi #(
    .NUM_CH(NCH),
    .CNT_W (CW),
    .CH_W  (CHW)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_high  (cfg_high),
    .cfg_low   (cfg_low),
    .cfg_phase (cfg_phase),
    .start     (start),
    .stop      (stop),
    .clk_out   (clk_out),
    .running   (running),
    .rise_pulse(rise_pulse),
    .cfg_err   (cfg_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic cfg_wr(input int ch, input int hi,
                        input int lo, input int ph);
    cfg_we    = 1'b1;
    cfg_ch    = CHW'(ch);
    cfg_high  = CW'(hi);
    cfg_low   = CW'(lo);
    cfg_phase = CW'(ph);
    step();
    cfg_we = 1'b0;
  endtask

  logic [23:0] p_clk;
  logic [23:0] p_rise;
  logic [7:0]  p_run;
  int          n_hi;
  int          n_lo;
  int          n_w;

  initial begin
    rst_n     = 1'b0;
    cfg_we    = 1'b0;
    cfg_ch    = '0;
    cfg_high  = '0;
    cfg_low   = '0;
    cfg_phase = '0;
    start     = '0;
    stop      = '0;

    // Reset state
    step();
    step();
    chk("rst clk_out", 32'(clk_out), 32'h0);
    chk("rst running", 32'(running), 32'h0);
    chk("rst rise", 32'(rise_pulse), 32'h0);
    chk("rst cfg_err", 32'(cfg_err), 32'h0);
    rst_n = 1'b1;
    step();

    // 1: default 1/1 on ch0
    start = 6'b000001;
    step();
    start = '0;
    chk("t1 run0", 32'(running), 32'h1);
    chk("t1 clk0 k", 32'(clk_out), 32'h0);
    for (int j = 1; j <= 6; j++) begin
      step();
      chk($sformatf("t1 clk j%0d", j),
          32'(clk_out), 32'(j % 2));
      chk($sformatf("t1 rise j%0d", j),
          32'(rise_pulse), 32'(j % 2));
      chk($sformatf("t1 run j%0d", j),
          32'(running), 32'h1);
    end
    stop = 6'b000001;
    step();
    stop = '0;
    repeat (4) step();
    chk("t1 stopped run", 32'(running), 32'h0);
    chk("t1 stopped clk", 32'(clk_out), 32'h0);

    // 2+3: ch1 3/2 phase 4, then 1/1
    cfg_wr(1, 3, 2, 4);
    chk("t2 cfg_err", 32'(cfg_err), 32'h0);
    start = 6'b000010;
    step();
    start = '0;
    chk("t2 run k", 32'(running), 32'h2);
    chk("t2 clk k", 32'(clk_out), 32'h0);
    p_clk  = 24'b1010_1001_1100_1110_0111_0000;
    p_rise = 24'b1010_1000_0100_0010_0001_0000;
    for (int j = 1; j <= 24; j++) begin
      step();
      chk($sformatf("t2 clk j%0d", j),
          32'(clk_out),
          32'({5'b0, p_clk[j-1]} << 1));
      chk($sformatf("t2 rise j%0d", j),
          32'(rise_pulse),
          32'({5'b0, p_rise[j-1]} << 1));
      if (j == 14) begin
        cfg_we    = 1'b1;
        cfg_ch    = 3'd1;
        cfg_high  = 8'd1;
        cfg_low   = 8'd1;
        cfg_phase = 8'd4;
      end
      if (j == 15) cfg_we = 1'b0;
    end
    stop = 6'b000010;
    step();
    stop = '0;
    repeat (4) step();
    chk("t3 stopped run", 32'(running), 32'h0);

    // 4: stop mid-HIGH completes period
    cfg_wr(1, 3, 2, 0);
    start = 6'b000010;
    step();
    start = '0;
    p_clk[7:0]  = 8'b0000_0111;
    p_run       = 8'b0000_1111;
    p_rise[7:0] = 8'b0000_0001;
    for (int j = 1; j <= 8; j++) begin
      step();
      chk($sformatf("t4 clk j%0d", j),
          32'(clk_out),
          32'({5'b0, p_clk[j-1]} << 1));
      chk($sformatf("t4 run j%0d", j),
          32'(running),
          32'({5'b0, p_run[j-1]} << 1));
      chk($sformatf("t4 rise j%0d", j),
          32'(rise_pulse),
          32'({5'b0, p_rise[j-1]} << 1));
      if (j == 2) stop = 6'b000010;
      if (j == 3) stop = '0;
    end

    // 5: rejected writes
    cfg_wr(2, 2, 1, 1);
    chk("t5 ok err", 32'(cfg_err), 32'h0);
    cfg_wr(2, 0, 5, 0);
    chk("t5 hi0 err", 32'(cfg_err), 32'h1);
    step();
    chk("t5 hi0 clr", 32'(cfg_err), 32'h0);
    cfg_wr(2, 5, 0, 0);
    chk("t5 lo0 err", 32'(cfg_err), 32'h1);
    step();
    chk("t5 lo0 clr", 32'(cfg_err), 32'h0);
    cfg_wr(7, 4, 4, 4);
    chk("t5 ch7 err", 32'(cfg_err), 32'h1);
    step();
    chk("t5 ch7 clr", 32'(cfg_err), 32'h0);
    cfg_wr(6, 4, 4, 4);
    chk("t5 ch6 err", 32'(cfg_err), 32'h1);
    step();
    chk("t5 ch6 clr", 32'(cfg_err), 32'h0);
    start = 6'b000100;
    step();
    start = '0;
    p_clk[6:0]  = 7'b011_0110;
    p_rise[6:0] = 7'b001_0010;
    for (int j = 1; j <= 7; j++) begin
      step();
      chk($sformatf("t5 clk j%0d", j),
          32'(clk_out),
          32'({5'b0, p_clk[j-1]} << 2));
      chk($sformatf("t5 rise j%0d", j),
          32'(rise_pulse),
          32'({5'b0, p_rise[j-1]} << 2));
    end

    // Max counter values on ch3
    cfg_wr(3, 255, 255, 0);
    start = 6'b001000;
    step();
    start = '0;
    step();
    chk("max first rise", 32'(rise_pulse[3]), 32'h1);
    n_hi = 0;
    while (clk_out[3] && n_hi < 600) begin
      n_hi++;
      step();
    end
    n_lo = 0;
    while (!clk_out[3] && n_lo < 600) begin
      n_lo++;
      step();
    end
    chk("max high len", 32'(n_hi), 32'd255);
    chk("max low len", 32'(n_lo), 32'd255);
    chk("max 2nd rise", 32'(rise_pulse[3]), 32'h1);

    // start+stop together while IDLE
    start = 6'b010000;
    stop  = 6'b010000;
    step();
    start = '0;
    stop  = '0;
    chk("ss run4", 32'(running[4]), 32'h0);
    step();
    chk("ss clk4", 32'(clk_out[4]), 32'h0);
    chk("ss run4 b", 32'(running[4]), 32'h0);

    // 6: async reset mid-HIGH
    n_w = 0;
    while (!clk_out[2] && n_w < 10) begin
      n_w++;
      step();
    end
    chk("t6 ch2 high", 32'(clk_out[2]), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6 async clk", 32'(clk_out), 32'h0);
    chk("t6 async run", 32'(running), 32'h0);
    chk("t6 async rise", 32'(rise_pulse), 32'h0);
    step();
    rst_n = 1'b1;
    start = 6'b000100;
    step();
    start = '0;
    step();
    chk("t6 rst cfg j1", 32'(clk_out), 32'h4);
    step();
    chk("t6 rst cfg j2", 32'(clk_out), 32'h0);
    step();
    chk("t6 rst cfg j3", 32'(clk_out), 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/clk_gen_multi.md
Name: clk_gen_multi

Overview:
- Synthesizable, parametrised multi-channel clock generator, clocked from the 100 MHz reference `clk`.
- Each channel outputs a registered divided clock with programmable high time, low time and start phase, all counted in reference cycles.
- Configuration uses shadow registers and is applied glitch-free at period boundaries.
- Channels start and stop cleanly with no runt pulses.
- Sits between the reference clock and downstream test/stimulus logic that needs derived clocks.

Parameters:
- NUM_CH, 4, number of output channels (must be >= 2).
- CNT_W, 16, width of the high, low and phase counters.
- CH_W, $clog2(NUM_CH), width of the channel select.

Ports:
- clk  input  1  reference clock; all logic on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- cfg_we  input  1  configuration write strobe, one cycle.
- cfg_ch  input  CH_W  channel addressed by cfg_we.
- cfg_high  input  CNT_W  high time in clk cycles.
- cfg_low  input  CNT_W  low time in clk cycles.
- cfg_phase  input  CNT_W  delay from start to first rising edge, in clk cycles.
- start  input  NUM_CH  per-channel start request, level sampled each cycle.
- stop  input  NUM_CH  per-channel stop request, level sampled each cycle.
- clk_out  output  NUM_CH  generated clocks, registered.
- running  output  NUM_CH  1 while the channel is in PHASE, HIGH or LOW.
- rise_pulse  output  NUM_CH  one-cycle strobe, asserted in the same cycle clk_out goes 0->1.
- cfg_err  output  1  one-cycle strobe when a configuration write is rejected.

Behaviour:
- Clock and reset
  - One clock; reset is asynchronous and active-low.
  - While rst_n=0: clk_out=0, running=0, rise_pulse=0, cfg_err=0, every channel IDLE.
  - Reset values: shadow and active high=1, low=1, phase=0.
  - Asserting rst_n mid-operation forces all of the above immediately, with no clock edge needed.
- Configuration writes
  - A write with cfg_we=1 is accepted only if cfg_ch<NUM_CH, cfg_high!=0 and cfg_low!=0.
  - An accepted write updates that channel's shadow registers at the edge.
  - A rejected write leaves all shadows unchanged and drives cfg_err=1 for the next cycle only.
- Shadow-to-active transfer
  - Shadow values copy into the active registers when a channel leaves IDLE.
  - They also copy at every LOW->HIGH transition, so a period in progress always completes with its old values.
- Per-channel FSM: IDLE, PHASE, HIGH, LOW.
  - IDLE: start=1 and stop=0 -> PHASE if phase!=0, else HIGH.
  - PHASE: count phase cycles, then HIGH. stop=1 -> IDLE at the next edge.
  - HIGH: clk_out=1 for exactly `high` cycles, then LOW.
  - LOW: clk_out=0 for exactly `low` cycles.
  - At the end of LOW: a stop is pending -> IDLE; otherwise -> HIGH, asserting rise_pulse.
- Timing
  - Start sampled at edge k: clk_out rises at edge k+1+phase.
  - Period is high+low cycles; duty is high/(high+low).
- Stop handling
  - A stop seen in HIGH or LOW sets a sticky pending flag.
  - The current HIGH and LOW always complete, so no shortened pulse is produced.
  - running falls in the same cycle the channel enters IDLE.
- Simultaneous events
  - start and stop together while IDLE: stop wins, channel stays IDLE.
  - start while running is ignored.
  - A cfg write to a running channel never affects the current period.
- Counters
  - CNT_W-bit down-counters loaded with value-1 and compared to 0.
  - A maximum value of 2^CNT_W-1 must work without wrap error.
- Channel independence
  - Channels are fully independent.
  - Channels started in the same cycle with identical config produce bit-identical clk_out.

Test Plan:
1. After reset, no cfg write, start[0] pulsed at edge k -> clk_out[0] rises at k+1 and toggles every cycle (period 2). rise_pulse[0] fires every 2 cycles; running[0]=1.
2. cfg ch1 high=3 low=2 phase=4, start[1] at edge k -> clk_out[1] rises at k+5, then repeats 3 high / 2 low. Other channels remain 0.
3. ch1 running 3/2; write high=1 low=1 during HIGH -> current 3/2 period completes, then a 1/1 pattern starts exactly at the next rising edge.
4. stop[1] asserted for one cycle in the 2nd HIGH cycle -> HIGH finishes (3 cycles) and LOW finishes (2 cycles). Then clk_out[1]=0 and running[1]=0; no further rise_pulse.
5. Invalid writes: cfg_high=0; cfg_low=0; cfg_ch=5 with NUM_CH=4 (CH_W=2 cannot express 5, so use NUM_CH=6, cfg_ch=7) -> cfg_err is a single-cycle pulse each time. Shadows are unchanged, verified by a subsequent start.
6. Edge cases: rst_n dropped between edges mid-HIGH -> clk_out, running and rise_pulse go 0 immediately. start+stop in the same cycle while IDLE -> channel stays IDLE.
